// File: rtl/arbitro_demux_n.sv
// 1-to-N demux with a per-channel FWFT FIFO and valid/ready upstream handshake.
// Define ARBITRO_DEMUX_ERR_EN to add err_dest and drop_cnt for out-of-range destinations.
module arbitro_demux_n #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               valid_in,
  input  logic [DW-1:0]      destiny,
  output logic               ready_out,
  input  logic [N-1:0]       pop,
  output logic [N*WIDTH-1:0] data_out,
  output logic [N-1:0]       valid_out,
  output logic [N-1:0]       full,
  output logic [N-1:0]       empty
`ifdef ARBITRO_DEMUX_ERR_EN
  ,
  output logic               err_dest,
  output logic [7:0]         drop_cnt
`endif
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam logic [DW:0] NUM_CH   = (DW+1)'(N);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic         in_range;
  logic [N-1:0] dest_hit;
  logic [N-1:0] push;
  logic [N-1:0] pop_ok;

  // Out-of-range destinations hit no channel, so they are always accepted and dropped.
  always_comb begin
    in_range = ({1'b0, destiny} < NUM_CH);
    for (int i = 0; i < N; i++) begin
      dest_hit[i] = in_range && (destiny == DW'(i));
    end
    ready_out = ~|(dest_hit & full);
    push      = {N{valid_in}} & dest_hit & ~full;
    pop_ok    = pop & ~empty;
  end

  for (genvar g = 0; g < N; g++) begin : gen_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      cnt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push[g]) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_ok[g]) rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push[g], pop_ok[g]})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    // Storage needs no reset: data_out is masked to zero while the channel is empty.
    always_ff @(posedge clk) begin
      if (!reset && push[g]) mem_q[wr_ptr_q] <= data_in;
    end

    assign full[g]                     = (cnt_q == FULL_CNT);
    assign empty[g]                    = (cnt_q == '0);
    assign valid_out[g]                = ~empty[g];
    assign data_out[g*WIDTH +: WIDTH]  = empty[g] ? '0 : mem_q[rd_ptr_q];
  end

`ifdef ARBITRO_DEMUX_ERR_EN
  logic oor_word;
  assign oor_word = valid_in && !in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_dest <= 1'b0;
      drop_cnt <= '0;
    end else if (oor_word) begin
      err_dest <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/arbitro_demux_n.md
Name: arbitro_demux_n

Overview:
- Parametrised 1-to-N demultiplexer on the arbiter output path, routing each word from the mux/arbiter stage to one of N destination channels selected by `destiny`.
- Each channel has its own first-word-fall-through (FWFT) FIFO with per-channel backpressure.
- Upstream sees a valid/ready handshake; downstream consumers drain their channel with `pop`.
- Replaces the fixed 2-way, 6-bit, combinational demux: outputs are registered and no words are lost.

Parameters:
- WIDTH, 6, data word width in bits.
- N, 4, number of output channels (2..16).
- DEPTH, 4, per-channel FIFO depth in words (power of 2, >=2).
- DW, 2, width of `destiny`; must satisfy 2**DW >= N.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  word from the arbiter/mux stage.
- valid_in  in  1  data_in is valid.
- destiny  in  DW  target channel index for data_in.
- ready_out  out  1  demux accepts data_in this cycle.
- pop  in  N  per-channel read strobe from the consumer.
- data_out  out  N*WIDTH  per-channel head word; channel i occupies bits [i*WIDTH +: WIDTH].
- valid_out  out  N  channel i head word is valid.
- full  out  N  channel i FIFO is full.
- empty  out  N  channel i FIFO is empty.

Behaviour:
- Reset: reset is sampled on the rising edge of clk. All read/write pointers and occupancy counts are cleared. Outputs after reset:
  - valid_out = 0, full = 0, empty = all 1s, data_out = 0.
  - ready_out = 1.
  - Optional-feature registers = 0.
  - Reset mid-operation discards all queued words; a push or pop presented in the reset cycle has no effect.
- ready_out is combinational from `destiny` and `full`:
  - if destiny < N, ready_out = !full[destiny];
  - otherwise ready_out = 1 (the word is consumed and discarded).
- Push: occurs when valid_in && ready_out && destiny < N. The word is written to FIFO[destiny] at that clock edge.
- Transfer rule: data_in is transferred only in a cycle where valid_in and ready_out are both high. Upstream holds data_in/destiny stable while valid_in=1 and ready_out=0.
- Latency: a word pushed at edge k appears on data_out[i] with valid_out[i]=1 immediately after edge k if channel i was empty. This is FWFT with 1 cycle of latency; there is no combinational path from data_in to data_out.
- Head/empty outputs: valid_out[i] = !empty[i]. data_out[i] shows the FIFO head when non-empty and 0 when empty.
- Pop: pop[i] with valid_out[i]=1 removes the head at the clock edge. pop[i] with empty[i]=1 is ignored: no pointer change and no underflow.
- Simultaneous push and pop on the same channel:
  - not full: both take effect and the occupancy count is unchanged;
  - full: the push is refused (ready_out=0, no bypass) and the pop proceeds.
- Independence: channels operate independently. A full channel blocks only words destined to it, and pops on other channels continue.
- Pointers: log2(DEPTH)-bit pointers wrap modulo DEPTH. A per-channel count of log2(DEPTH)+1 bits drives full (count==DEPTH) and empty (count==0).
- Flag timing: full and empty are registered-state derived and update in the cycle after the push/pop edge.
- Ordering: per-channel FIFO order is preserved; there is no ordering guarantee across channels.

Optional Feature:
- Macro: ARBITRO_DEMUX_ERR_EN.
- When defined, the block adds:
  - output err_dest (1 bit): a sticky flag, set at the edge where valid_in=1 and destiny >= N; cleared only by reset.
  - output drop_cnt (8 bits): counts discarded out-of-range words, saturating at 255.
- When not defined, out-of-range words are silently discarded and neither port exists.

Test Plan:
- Reset: hold reset=1 for 2 cycles with valid_in=1, destiny=1 -> after release valid_out=0000, empty=1111, full=0000, ready_out=1, data_out all 0.
- Single route: push 6'h2A to destiny=2, no pops -> next cycle valid_out=0100 and data_out[2]=6'h2A. pop[2]=1 for one cycle -> valid_out=0000.
- Fill/backpressure: push 6'h01..6'h04 to channel 0 (DEPTH=4) -> full[0]=1. A 5th word (6'h05) with destiny=0 sees ready_out=0 and is held. Pop once -> 6'h05 is accepted next cycle. Draining yields 01,02,03,04,05 in order.
- Channel independence: channel 0 full, push 6'h11 to destiny=3 -> ready_out=1 and data_out[3]=6'h11 while channel 0 stays blocked.
- Simultaneous push/pop on channel 1 holding 2 words -> count stays 2 and head advances. Pop on empty channel 2 -> no change, empty[2] stays 1.
- N=3, destiny=3, valid_in=1 -> ready_out=1 and no channel written. With ARBITRO_DEMUX_ERR_EN: err_dest=1 and drop_cnt=1; 300 such words -> drop_cnt=255.
